mr_ifetch_pf: RTL and testbench

Parametrised prefetching instruction fetch unit. It replaces the single-request stub fetch stage.
- Issues pipelined Wishbone B4 reads with up to MAX_OUTSTANDING requests in flight.
- Buffers responses in a DEPTH-entry FIFO and presents them to ID with a valid/ready handshake.
- Supports redirects from WB (flush plus bus abort) and reports bus errors to ID as tagged fault entries.

---
 rtl/mr_ifetch_pf.sv | 130 +++++++++++++
 tb/tb_mr_ifetch_pf.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mr_ifetch_pf.sv
// Prefetching instruction fetch: pipelined Wishbone B4 reads into a small FIFO
// feeding ID over valid/ready, with redirect flush and tagged bus-error entries.
module mr_ifetch_pf #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_VEC       = '0,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-3:0] adr_o,
  output logic            stb_o,
  output logic            cyc_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic            stall_i,
  input  logic [XLEN-1:0] dat_i,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  output logic            inst_valid,
  input  logic            id_ready,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            redir_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] MAX_W   = PW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   outst;
  logic            halted;
  logic            stb;
  logic            cyc;

  logic [31:0]     mem_inst  [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic            mem_fault [DEPTH];

  logic [PW-1:0] count;
  logic [PW-1:0] count_n;
  logic [PW-1:0] outst_n;
  logic [CW-1:0] credit_sum;
  logic          pop;
  logic          accept;
  logic          ack;
  logic          err;
  logic          push;
  logic          credit;
  logic          stb_n;
  logic          unused_redir_lsb;

  assign unused_redir_lsb = &{1'b0, redir_pc[1:0]};

  always_comb begin
    count      = wr_ptr - rd_ptr;
    pop        = (count != '0) && id_ready;
    accept     = stb && !stall_i;
    ack        = ack_i && cyc;
    err        = err_i && cyc;
    push       = ack || err;
    outst_n    = outst + {{(PW-1){1'b0}}, accept} - {{(PW-1){1'b0}}, ack};
    count_n    = count + {{(PW-1){1'b0}}, push} - {{(PW-1){1'b0}}, pop};
    credit_sum = CW'(count_n) + CW'(outst_n);
    // Credit is judged on post-edge occupancy so the FIFO can never overflow.
    credit     = !halted && (outst_n < MAX_W) && (credit_sum < DEPTH_W);
    stb_n      = (stb && stall_i) || credit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_VEC;
      resp_pc  <= RESET_VEC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      outst    <= '0;
      halted   <= 1'b0;
      stb      <= 1'b0;
      cyc      <= 1'b0;
    end else if (redir_valid) begin
      fetch_pc <= {redir_pc[XLEN-1:2], 2'b00};
      resp_pc  <= {redir_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= wr_ptr;
      outst    <= '0;
      halted   <= 1'b0;
      stb      <= 1'b0;
      cyc      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (err) begin
        halted <= 1'b1;
        outst  <= '0;
        stb    <= 1'b0;
        cyc    <= 1'b0;
      end else begin
        outst <= outst_n;
        stb   <= stb_n;
        cyc   <= stb_n || (outst_n != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redir_valid && push) begin
      mem_inst[wr_ptr[AW-1:0]]  <= err ? '0 : dat_i;
      mem_pc[wr_ptr[AW-1:0]]    <= resp_pc;
      mem_fault[wr_ptr[AW-1:0]] <= err;
    end
  end

  assign adr_o      = fetch_pc[XLEN-1:2];
  assign stb_o      = stb;
  assign cyc_o      = cyc;
  assign inst_valid = (count != '0);
  assign inst       = mem_inst[rd_ptr[AW-1:0]];
  assign inst_pc    = mem_pc[rd_ptr[AW-1:0]];
  assign inst_fault = inst_valid && mem_fault[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_mr_ifetch_pf.sv
// Directed bench for mr_ifetch_pf: zero-wait Wishbone slave model plus an ID
// consumer that checks every popped entry against the expected PC stream.
module tb_mr_ifetch_pf;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] adr_o;
  logic        stb_o, cyc_o;
  logic        ack_i, err_i, stall_i;
  logic [31:0] dat_i;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault, inst_valid;
  logic        id_ready;
  logic [31:0] redir_pc;
  logic        redir_valid;

  mr_ifetch_pf #(.XLEN(32), .RESET_VEC(32'h0), .DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .adr_o(adr_o), .stb_o(stb_o), .cyc_o(cyc_o),
    .ack_i(ack_i), .err_i(err_i), .stall_i(stall_i), .dat_i(dat_i),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault), .inst_valid(inst_valid),
    .id_ready(id_ready), .redir_pc(redir_pc), .redir_valid(redir_valid)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  logic [29:0] q[$];
  int          ack_budget;
  logic [31:0] err_byte;
  logic [31:0] exp_pc;
  int          acc_cnt, stb_cnt, pop_cnt, maxq;

  function automatic logic [31:0] fdat(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: slave responds, ID consumes, then the clock edge.
  task automatic tick();
    logic [29:0] a;
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = '0;
    if (rst || !cyc_o) q.delete();
    else if (q.size() > 0 && ack_budget != 0) begin
      a = q.pop_front();
      if (ack_budget > 0) ack_budget--;
      if ({a, 2'b00} == err_byte) err_i = 1'b1;
      else begin
        ack_i = 1'b1;
        dat_i = fdat({a, 2'b00});
      end
    end
    if (!rst && stb_o && !stall_i) begin
      q.push_back(adr_o);
      acc_cnt++;
    end
    if (q.size() > maxq) maxq = q.size();
    if (stb_o) stb_cnt++;
    if (!rst && !redir_valid && inst_valid && id_ready) begin
      check("pop_pc", inst_pc, exp_pc);
      check("pop_fault", inst_fault, exp_pc == err_byte);
      check("pop_inst", inst, (exp_pc == err_byte) ? 32'h0 : fdat(exp_pc));
      exp_pc += 32'd4;
      pop_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; stall_i = 1'b0; id_ready = 1'b0;
    redir_valid = 1'b0; redir_pc = '0;
    ack_budget = -1; err_byte = 32'hFFFF_FFFF;
    tick();
    tick();
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_fault", inst_fault, 0);
    check("rst_adr", adr_o, 0);
    rst = 1'b0;
    exp_pc = 32'h0; maxq = 0; acc_cnt = 0; stb_cnt = 0; pop_cnt = 0;
  endtask

  initial begin
    int gaps, n, stb0, acc0;
    logic [29:0] a0;
    ack_i = 0; err_i = 0; dat_i = '0;

    // Streaming with zero-wait slave
    reset_dut();
    id_ready = 1'b1;
    tick(); check("first_stb", stb_o, 1);
    tick(); check("valid_lat0", inst_valid, 0);
    tick(); check("valid_lat1", inst_valid, 1);
    gaps = 0;
    repeat (20) begin tick(); if (!inst_valid) gaps++; end
    check("stream_gaps", gaps, 0);
    check("stream_pops", pop_cnt, 20);
    check("max_outst", maxq <= 2, 1);

    // Back-pressure from ID fills the FIFO and stops fetching
    reset_dut();
    repeat (20) tick();
    check("bp_accepts", acc_cnt, 4);
    check("bp_stb", stb_o, 0);
    check("bp_valid", inst_valid, 1);
    id_ready = 1'b1; tick(); id_ready = 1'b0;
    repeat (10) tick();
    check("bp_one_more", acc_cnt, 5);
    check("bp_stb2", stb_o, 0);
    id_ready = 1'b1;
    repeat (10) tick();
    check("bp_drain", pop_cnt >= 5, 1);

    // Slave stall holds address
    reset_dut();
    id_ready = 1'b1;
    tick();
    stall_i = 1'b1; a0 = adr_o; acc0 = acc_cnt;
    repeat (3) begin
      tick();
      check("stall_adr", adr_o, a0);
      check("stall_stb", stb_o, 1);
    end
    check("stall_noacc", acc_cnt, acc0);
    stall_i = 1'b0;
    tick();
    check("stall_oneacc", acc_cnt, acc0 + 1);
    repeat (10) tick();
    check("stall_pops", pop_cnt >= 8, 1);

    // Redirect with requests outstanding and a late ack
    reset_dut();
    ack_budget = 2;
    n = 0;
    while (q.size() != 2 && n < 20) begin tick(); n++; end
    check("redir_setup_outst", q.size(), 2);
    check("redir_setup_valid", inst_valid, 1);
    redir_valid = 1'b1; redir_pc = 32'h103; ack_budget = -1;
    tick();
    check("redir_cyc", cyc_o, 0);
    check("redir_stb", stb_o, 0);
    check("redir_valid_clr", inst_valid, 0);
    redir_valid = 1'b0; exp_pc = 32'h100;
    tick();
    check("redir_stb_resume", stb_o, 1);
    check("redir_adr", adr_o, 30'h40);
    check("redir_no_late_push", inst_valid, 0);
    id_ready = 1'b1;
    repeat (8) tick();
    check("redir_pops", pop_cnt >= 4, 1);

    // Bus error on PC 0x8
    reset_dut();
    err_byte = 32'h8; id_ready = 1'b1;
    repeat (6) tick();
    stb0 = stb_cnt;
    repeat (10) tick();
    check("err_no_stb", stb_cnt, stb0);
    check("err_pops", pop_cnt, 3);
    check("err_empty", inst_valid, 0);
    check("err_cyc", cyc_o, 0);
    redir_valid = 1'b1; redir_pc = 32'h20;
    tick();
    redir_valid = 1'b0; exp_pc = 32'h20; err_byte = 32'hFFFF_FFFF;
    repeat (8) tick();
    check("err_resume", pop_cnt > 3, 1);

    // Reset while stalled strobe is up
    reset_dut();
    tick();
    stall_i = 1'b1;
    tick();
    check("rst_pre_stb", stb_o, 1);
    rst = 1'b1;
    tick();
    check("rstmid_cyc", cyc_o, 0);
    check("rstmid_stb", stb_o, 0);
    check("rstmid_valid", inst_valid, 0);
    check("rstmid_adr", adr_o, 0);
    rst = 1'b0; stall_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
